// File: rtl/trace_stimulus_player.sv
// trace_stimulus_player: replays a stored event trace as timed per-channel
// pulses, with stall back-pressure, loop replay and late-event accounting.
module trace_stimulus_player #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [TS_W-1:0]          wr_delta,
    input  logic [NUM_CH-1:0]        wr_mask,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    input  logic [ADDR_W:0]          num_events,
    input  logic                     loop_mode,
    input  logic                     start,
    input  logic                     stall,
    output logic [NUM_CH*DATA_W-1:0] input_data,
    output logic [NUM_CH-1:0]        new_input,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W-1:0]        ev_idx,
    output logic [15:0]              late_cnt
);

    localparam int DW = NUM_CH * DATA_W;
    localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FIRE,
        S_DONE
    } state_t;

    logic [TS_W-1:0]   mem_delta [DEPTH];
    logic [NUM_CH-1:0] mem_mask  [DEPTH];
    logic [DW-1:0]     mem_data  [DEPTH];

    state_t            state_q, state_d;
    logic [TS_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   num_q, num_d;
    logic              loop_q, loop_d;
    logic              last_q, last_d;
    logic [TS_W-1:0]   pend_delta_q, pend_delta_d;
    logic [NUM_CH-1:0] pend_mask_q, pend_mask_d;
    logic [DW-1:0]     pend_data_q, pend_data_d;
    logic [NUM_CH-1:0] nin_q, nin_d;
    logic [DW-1:0]     data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [15:0]       late_q, late_d;

    logic              idle_like;
    logic              wr_ok;
    logic              is_last;
    logic              due;
    logic [ADDR_W-1:0] nxt_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic [TS_W-1:0]   cnt_inc;
    logic [TS_W-1:0]   rd_delta;
    logic [NUM_CH-1:0] rd_mask;
    logic [DW-1:0]     rd_data;
    logic [DW-1:0]     masked;
    logic [ADDR_W:0]   num_eff;

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign wr_ok     = en && wr_en && idle_like;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_delta[wr_addr] <= wr_delta;
            mem_mask[wr_addr]  <= wr_mask;
            mem_data[wr_addr]  <= wr_data;
        end
    end

    assign is_last = ({1'b0, idx_q} == (num_q - (ADDR_W + 1)'(1)));
    assign nxt_idx = is_last ? '0 : idx_q + ADDR_W'(1);
    assign cnt_inc = cnt_q + TS_W'(1);
    // cnt_inc is never below 1, so a zero delta behaves as one
    assign due     = (cnt_inc >= pend_delta_q);
    assign num_eff = (num_events > DEPTH_N) ? DEPTH_N : num_events;

    // Pending-event prefetch; a write in the start cycle is forwarded
    assign rd_addr = idle_like ? '0 : nxt_idx;

    always_comb begin
        rd_delta = mem_delta[rd_addr];
        rd_mask  = mem_mask[rd_addr];
        rd_data  = mem_data[rd_addr];
        if (wr_ok && (wr_addr == rd_addr)) begin
            rd_delta = wr_delta;
            rd_mask  = wr_mask;
            rd_data  = wr_data;
        end
    end

    always_comb begin
        masked = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pend_mask_q[i]) begin
                masked[i*DATA_W +: DATA_W] = pend_data_q[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        num_d        = num_q;
        loop_d       = loop_q;
        last_d       = last_q;
        pend_delta_d = pend_delta_q;
        pend_mask_d  = pend_mask_q;
        pend_data_d  = pend_data_q;
        nin_d        = '0;
        data_d       = '0;
        late_d       = late_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (num_eff == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d      = S_WAIT;
                        cnt_d        = '0;
                        idx_d        = '0;
                        num_d        = num_eff;
                        loop_d       = loop_mode;
                        last_d       = 1'b0;
                        pend_delta_d = rd_delta;
                        pend_mask_d  = rd_mask;
                        pend_data_d  = rd_data;
                    end
                end
            end
            S_WAIT, S_FIRE: begin
                if ((state_q == S_FIRE) && last_q) begin
                    state_d = S_DONE;
                end else begin
                    // FIRE doubles as the first wait cycle of the next event
                    state_d = S_WAIT;
                    if (!due) begin
                        cnt_d = cnt_inc;
                    end else if (stall) begin
                        if (late_q != 16'hFFFF) begin
                            late_d = late_q + 16'd1;
                        end
                    end else begin
                        state_d      = S_FIRE;
                        cnt_d        = '0;
                        nin_d        = pend_mask_q;
                        data_d       = masked;
                        idx_d        = nxt_idx;
                        last_d       = is_last && !loop_q;
                        pend_delta_d = rd_delta;
                        pend_mask_d  = rd_mask;
                        pend_data_d  = rd_data;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_WAIT) || (state_d == S_FIRE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            num_q        <= '0;
            loop_q       <= 1'b0;
            last_q       <= 1'b0;
            pend_delta_q <= '0;
            pend_mask_q  <= '0;
            pend_data_q  <= '0;
            nin_q        <= '0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            late_q       <= '0;
        end else if (en) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            num_q        <= num_d;
            loop_q       <= loop_d;
            last_q       <= last_d;
            pend_delta_q <= pend_delta_d;
            pend_mask_q  <= pend_mask_d;
            pend_data_q  <= pend_data_d;
            nin_q        <= nin_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            late_q       <= late_d;
        end
    end

    assign new_input  = nin_q & {NUM_CH{en}};
    assign input_data = data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ev_idx     = idx_q;
    assign late_cnt   = late_q;

endmodule

// File: tb/tb_trace_stimulus_player.sv
// Directed bench for trace_stimulus_player: timing, masks, stall,
// loop, clamping, reset, enable and write-port rules.
module tb_trace_stimulus_player;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 16;
    localparam int TS_W   = 32;
    localparam int ADDR_W = 4;

    logic                     clk;
    logic                     rst;
    logic                     en;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [TS_W-1:0]          wr_delta;
    logic [NUM_CH-1:0]        wr_mask;
    logic [NUM_CH*DATA_W-1:0] wr_data;
    logic [ADDR_W:0]          num_events;
    logic                     loop_mode;
    logic                     start;
    logic                     stall;
    logic [NUM_CH*DATA_W-1:0] input_data;
    logic [NUM_CH-1:0]        new_input;
    logic                     busy;
    logic                     done;
    logic [ADDR_W-1:0]        ev_idx;
    logic [15:0]              late_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    int            pt [32];
    logic [1:0]    pm [32];
    logic [127:0]  pd [32];
    int            pc;
    bit            done_seen;

    trace_stimulus_player #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .TS_W(TS_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_delta(wr_delta),
        .wr_mask(wr_mask), .wr_data(wr_data),
        .num_events(num_events), .loop_mode(loop_mode),
        .start(start), .stall(stall),
        .input_data(input_data), .new_input(new_input),
        .busy(busy), .done(done), .ev_idx(ev_idx), .late_cnt(late_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wr(input int a, input int d, input logic [1:0] m,
                      input logic [63:0] v0, input logic [63:0] v1);
        wr_en = 1'b1; wr_addr = a[3:0]; wr_delta = d;
        wr_mask = m; wr_data = {v1, v0};
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic go(input int num, input bit lp);
        num_events = num[4:0]; loop_mode = lp; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // n counts edges after the start edge; stall/en ranges apply from edge n+1
    task automatic capture(input int cycles, input int s_from, input int s_to,
                           input int e_from, input int e_to);
        pc = 0; done_seen = 0;
        for (int i = 0; i < 32; i++) begin
            pt[i] = -1; pm[i] = '0; pd[i] = '0;
        end
        for (int n = 1; n <= cycles; n++) begin
            @(posedge clk); #1;
            if (new_input != 2'b00 && pc < 32) begin
                pt[pc] = n; pm[pc] = new_input; pd[pc] = input_data; pc++;
            end
            if (done) done_seen = 1;
            stall = (n >= s_from && n < s_to);
            en = !(n >= e_from && n < e_to);
        end
        stall = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        n_cmp++; if (new_input !== 2'b00) begin n_bad++; $display("FAIL reset_new_input got %b want 00", new_input); end
        n_cmp++; if (input_data !== '0) begin n_bad++; $display("FAIL reset_input_data got %h want 0", input_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (ev_idx !== 4'd0) begin n_bad++; $display("FAIL reset_ev_idx got %0d want 0", ev_idx); end
        n_cmp++; if (late_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_late got %0d want 0", late_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_seven();
        int et [7] = '{500, 1000, 1500, 2000, 2500, 3500, 4000};
        int ev [7] = '{1, 2, 3, 4, 5, 7, 8};
        do_reset();
        for (int i = 0; i < 7; i++)
            wr(i, (i == 5) ? 1000 : 500, 2'b11, 64'(ev[i]), 64'(ev[i] + 100));
        go(7, 0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL seven_busy got %b want 1", busy); end
        capture(4010, 0, 0, 0, 0);
        n_cmp++; if (pc != 7) begin n_bad++; $display("FAIL seven_count got %0d want 7", pc); end
        for (int i = 0; i < 7; i++) begin
            n_cmp++; if (pt[i] != et[i]) begin n_bad++; $display("FAIL seven_time[%0d] got %0d want %0d", i, pt[i], et[i]); end
            n_cmp++; if (pm[i] !== 2'b11) begin n_bad++; $display("FAIL seven_mask[%0d] got %b want 11", i, pm[i]); end
            n_cmp++; if (pd[i] !== {64'(ev[i] + 100), 64'(ev[i])}) begin
                n_bad++; $display("FAIL seven_data[%0d] got %h want %h", i, pd[i], {64'(ev[i] + 100), 64'(ev[i])});
            end
        end
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL seven_done got done=%b busy=%b want 1/0", done, busy); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]   em [3] = '{2'b01, 2'b10, 2'b11};
        logic [127:0] ed [3];
        ed[0] = {64'h0, 64'h11};
        ed[1] = {64'h22, 64'h0};
        ed[2] = {64'h23, 64'h13};
        do_reset();
        wr(0, 1, 2'b01, 64'h11, 64'h21);
        wr(1, 1, 2'b10, 64'h12, 64'h22);
        wr(2, 1, 2'b11, 64'h13, 64'h23);
        go(3, 0);
        capture(6, 0, 0, 0, 0);
        n_cmp++; if (pc != 3) begin n_bad++; $display("FAIL b2b_count got %0d want 3", pc); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (pt[i] != i + 1) begin n_bad++; $display("FAIL b2b_time[%0d] got %0d want %0d", i, pt[i], i + 1); end
            n_cmp++; if (pm[i] !== em[i]) begin n_bad++; $display("FAIL b2b_mask[%0d] got %b want %b", i, pm[i], em[i]); end
            n_cmp++; if (pd[i] !== ed[i]) begin n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", i, pd[i], ed[i]); end
        end
        n_cmp++; if (done !== 1'b1 || input_data !== '0) begin n_bad++; $display("FAIL b2b_done got done=%b data=%h want 1/0", done, input_data); end
    endtask

    task automatic test_stall();
        int et [3] = '{5, 21, 25};
        do_reset();
        wr(0, 5, 2'b11, 64'd1, 64'd1);
        wr(1, 6, 2'b11, 64'd2, 64'd2);
        wr(2, 4, 2'b11, 64'd3, 64'd3);
        go(3, 0);
        capture(40, 10, 20, 0, 0);
        n_cmp++; if (pc != 3) begin n_bad++; $display("FAIL stall_count got %0d want 3", pc); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (pt[i] != et[i]) begin n_bad++; $display("FAIL stall_time[%0d] got %0d want %0d", i, pt[i], et[i]); end
        end
        n_cmp++; if (late_cnt !== 16'd10) begin n_bad++; $display("FAIL stall_late got %0d want 10", late_cnt); end
    endtask

    task automatic test_loop();
        int et [8] = '{3, 7, 10, 14, 17, 21, 24, 28};
        do_reset();
        wr(0, 3, 2'b01, 64'd5, 64'd0);
        wr(1, 4, 2'b10, 64'd0, 64'd6);
        go(2, 1);
        capture(30, 0, 0, 0, 0);
        n_cmp++; if (pc != 8) begin n_bad++; $display("FAIL loop_count got %0d want 8", pc); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (pt[i] != et[i]) begin n_bad++; $display("FAIL loop_time[%0d] got %0d want %0d", i, pt[i], et[i]); end
            n_cmp++; if (pm[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin n_bad++; $display("FAIL loop_mask[%0d] got %b", i, pm[i]); end
        end
        n_cmp++; if (done_seen || busy !== 1'b1) begin n_bad++; $display("FAIL loop_done got done_seen=%0d busy=%b want 0/1", done_seen, busy); end
        do_reset();
    endtask

    task automatic test_zero_events();
        do_reset();
        go(0, 0);
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL zero_done got done=%b busy=%b want 1/0", done, busy); end
        capture(10, 0, 0, 0, 0);
        n_cmp++; if (pc != 0) begin n_bad++; $display("FAIL zero_pulses got %0d want 0", pc); end
    endtask

    task automatic test_clamp();
        do_reset();
        for (int i = 0; i < 16; i++) wr(i, 1, 2'b01, 64'(i), 64'd99);
        go(20, 0);
        capture(20, 0, 0, 0, 0);
        n_cmp++; if (pc != 16) begin n_bad++; $display("FAIL clamp_count got %0d want 16", pc); end
        n_cmp++; if (pt[0] != 1 || pt[15] != 16) begin n_bad++; $display("FAIL clamp_time got %0d/%0d want 1/16", pt[0], pt[15]); end
        n_cmp++; if (pd[15] !== {64'd0, 64'd15}) begin n_bad++; $display("FAIL clamp_data got %h want f", pd[15]); end
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL clamp_done got %b want 1", done); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr(0, 4, 2'b11, 64'd9, 64'd19);
        wr(1, 20, 2'b11, 64'd10, 64'd10);
        go(2, 0);
        capture(21, 3, 6, 0, 0);
        n_cmp++; if (pt[0] != 7 || late_cnt !== 16'd3) begin n_bad++; $display("FAIL rmid_pre got t=%0d late=%0d want 7/3", pt[0], late_cnt); end
        do_reset();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || new_input !== 2'b00 || input_data !== '0 || ev_idx !== 4'd0 || late_cnt !== 16'd0) begin
            n_bad++; $display("FAIL rmid_outputs got busy=%b done=%b nin=%b data=%h idx=%0d late=%0d want all 0", busy, done, new_input, input_data, ev_idx, late_cnt);
        end
        capture(20, 0, 0, 0, 0);
        n_cmp++; if (pc != 0) begin n_bad++; $display("FAIL rmid_dropped got %0d pulses want 0", pc); end
        go(2, 0);
        capture(8, 0, 0, 0, 0);
        n_cmp++; if (pc != 1 || pt[0] != 4 || pd[0] !== {64'd19, 64'd9}) begin
            n_bad++; $display("FAIL rmid_replay got n=%0d t=%0d d=%h want 1/4/13_9", pc, pt[0], pd[0]);
        end
    endtask

    task automatic test_enable();
        do_reset();
        wr(0, 50, 2'b01, 64'd77, 64'd0);
        go(1, 0);
        capture(80, 0, 0, 10, 30);
        n_cmp++; if (pc != 1 || pt[0] != 70) begin n_bad++; $display("FAIL en_shift got n=%0d t=%0d want 1/70", pc, pt[0]); end
        n_cmp++; if (pd[0] !== {64'd0, 64'd77}) begin n_bad++; $display("FAIL en_data got %h want 4d", pd[0]); end
    endtask

    task automatic test_write_rules();
        do_reset();
        wr(0, 8, 2'b11, 64'hA0, 64'hA1);
        go(1, 0);
        wr(0, 3, 2'b11, 64'hB0, 64'hB1);
        capture(12, 0, 0, 0, 0);
        // the ignored write consumed edge 1, so the edge-8 pulse lands at n=7
        n_cmp++; if (pc != 1 || pt[0] != 7) begin n_bad++; $display("FAIL wbusy_time got n=%0d t=%0d want 1/7", pc, pt[0]); end
        n_cmp++; if (pd[0] !== {64'hA1, 64'hA0}) begin n_bad++; $display("FAIL wbusy_data got %h want a1_a0", pd[0]); end
        wr_en = 1'b1; wr_addr = 4'd0; wr_delta = 2; wr_mask = 2'b10;
        wr_data = {64'hC1, 64'hC0};
        num_events = 5'd1; loop_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0; start = 1'b0;
        capture(5, 0, 0, 0, 0);
        n_cmp++; if (pc != 1 || pt[0] != 2) begin n_bad++; $display("FAIL wstart_time got n=%0d t=%0d want 1/2", pc, pt[0]); end
        n_cmp++; if (pm[0] !== 2'b10 || pd[0] !== {64'hC1, 64'h0}) begin
            n_bad++; $display("FAIL wstart_data got m=%b d=%h want 10/c1_0", pm[0], pd[0]);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_delta = '0;
        wr_mask = '0; wr_data = '0; num_events = '0; loop_mode = 1'b0;
        start = 1'b0; stall = 1'b0;
        test_reset();
        test_seven();
        test_back_to_back();
        test_stall();
        test_loop();
        test_zero_events();
        test_clamp();
        test_reset_mid();
        test_enable();
        test_write_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
